// File: rtl/mfp_input_debouncer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mfp_input_debouncer_pkg
// Description : Shared defaults and filter state encoding for the input debouncer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

// Board-level defaults; simulation builds override MFP_DB_CYCLES with a small value.
`ifndef MFP_N_SW
`define MFP_N_SW 16
`endif
`ifndef MFP_N_PB
`define MFP_N_PB 5
`endif
`ifndef MFP_DB_CYCLES
`define MFP_DB_CYCLES 50000
`endif

package mfp_input_debouncer_pkg;

  localparam int c_n_sw_dflt      = `MFP_N_SW;
  localparam int c_n_pb_dflt      = `MFP_N_PB;
  localparam int c_db_cycles_dflt = `MFP_DB_CYCLES;

  localparam int               c_st_w       = 1;
  localparam logic [c_st_w-1:0] c_st_stable  = 1'b0;
  localparam logic [c_st_w-1:0] c_st_pending = 1'b1;

  // Counter only needs to reach DB_CYCLES-1.
  function automatic int db_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mfp_debounce_bit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mfp_debounce_bit
// Description : Two-flop synchroniser plus per-bit stability filter for one pin.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module mfp_debounce_bit
  import mfp_input_debouncer_pkg::*;
#(
  parameter int DB_CYCLES = c_db_cycles_dflt
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic i_raw,
  output logic o_level
);

  localparam int               CNT_W      = db_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_term = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_level;
  logic [c_st_w-1:0] r_state;
  logic [c_st_w-1:0] w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_level_nxt;
  logic              w_differs;
  logic              w_term;

  assign w_differs = (r_sync2 != r_level);
  assign w_term    = (r_cnt == c_cnt_term);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= c_st_stable;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_stable:  if (w_differs) w_state_nxt = c_st_pending;
      c_st_pending: if (!w_differs || w_term) w_state_nxt = c_st_stable;
      default:      w_state_nxt = c_st_stable;
    endcase
  end

  // A glitch that ends before terminal count leaves the counter cleared.
  always_comb begin
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    if ((r_state == c_st_pending) && w_differs) begin
      if (w_term) begin
        w_level_nxt = r_sync2;
      end else begin
        w_cnt_nxt = r_cnt + c_cnt_one;
      end
    end
  end

  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/mfp_input_debouncer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mfp_input_debouncer
// Description : Debounces board switches/buttons for the GPIO block; define
//               MFP_DB_EDGE_EN to build the PB_press/PB_release pulse logic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module mfp_input_debouncer
  import mfp_input_debouncer_pkg::*;
#(
  parameter int N_SW      = c_n_sw_dflt,
  parameter int N_PB      = c_n_pb_dflt,
  parameter int DB_CYCLES = c_db_cycles_dflt
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [N_SW-1:0] SW_raw,
  input  logic [N_PB-1:0] PB_raw,
  output logic [N_SW-1:0] IO_Switch,
  output logic [N_PB-1:0] IO_PB,
  output logic [N_PB-1:0] PB_press,
  output logic [N_PB-1:0] PB_release
);

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
    mfp_debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_bit (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .i_raw   (SW_raw[gi]),
      .o_level (IO_Switch[gi])
    );
  end

  for (genvar gi = 0; gi < N_PB; gi++) begin : g_pb
    mfp_debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_bit (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .i_raw   (PB_raw[gi]),
      .o_level (IO_PB[gi])
    );
  end

`ifdef MFP_DB_EDGE_EN
  logic [N_PB-1:0] r_pb_prev;
  logic [N_PB-1:0] r_press;
  logic [N_PB-1:0] r_release;

  // r_pb_prev clears to 0, so a button held through reset yields a press.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pb_prev <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_pb_prev <= IO_PB;
      r_press   <= IO_PB & ~r_pb_prev;
      r_release <= ~IO_PB & r_pb_prev;
    end
  end

  assign PB_press   = r_press;
  assign PB_release = r_release;
`else
  assign PB_press   = '0;
  assign PB_release = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mfp_input_debouncer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mfp_input_debouncer
// Description : Self-checking bench for mfp_input_debouncer with DB_CYCLES = 4.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module tb_mfp_input_debouncer;

  localparam int N_SW = 16;
  localparam int N_PB = 5;
  localparam int DB   = 4;
`ifdef MFP_DB_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] sw;
    logic [4:0]  pb;
    logic [4:0]  pr;
    logic [4:0]  rl;
  } exp_t;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [N_SW-1:0] SW_raw;
  logic [N_PB-1:0] PB_raw;
  logic [N_SW-1:0] IO_Switch;
  logic [N_PB-1:0] IO_PB;
  logic [N_PB-1:0] PB_press;
  logic [N_PB-1:0] PB_release;

  exp_t obs;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  assign obs = {IO_Switch, IO_PB, PB_press, PB_release};

  initial forever #5 HCLK = ~HCLK;

  mfp_input_debouncer #(
    .N_SW      (N_SW),
    .N_PB      (N_PB),
    .DB_CYCLES (DB)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .SW_raw     (SW_raw),
    .PB_raw     (PB_raw),
    .IO_Switch  (IO_Switch),
    .IO_PB      (IO_PB),
    .PB_press   (PB_press),
    .PB_release (PB_release)
  );

  // Pulses are only expected when the edge logic is built in.
  function automatic exp_t mk(input logic [15:0] sw, input logic [4:0] pb,
                              input logic [4:0] pr, input logic [4:0] rl);
    exp_t e;
    e.sw = sw;
    e.pb = pb;
    e.pr = EDGE_EN ? pr : 5'b0;
    e.rl = EDGE_EN ? rl : 5'b0;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    HRESETn = 1'b0;
    SW_raw  = 16'hFFFF;
    PB_raw  = 5'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK); #1;
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got sw=%h pb=%b pr=%b rl=%b, required all zero",
                 k, obs.sw, obs.pb, obs.pr, obs.rl);
      end
    end
    HRESETn = 1'b1;
    for (int k = 0; k < 8; k++) q.push_back(mk((k >= 6) ? 16'hFFFF : 16'h0, 5'b0, 5'b0, 5'b0));
    for (int k = 0; k < 8; k++) begin
      @(posedge HCLK); #1;
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got sw=%h pb=%b pr=%b rl=%b, required sw=%h pb=%b pr=%b rl=%b",
                 k, obs.sw, obs.pb, obs.pr, obs.rl, e.sw, e.pb, e.pr, e.rl);
      end
    end
  endtask

  task automatic test_clean_press();
    exp_t e;
    PB_raw = 5'b00001;
    for (int k = 0; k < 10; k++)
      q.push_back(mk(16'hFFFF, (k >= 6) ? 5'b00001 : 5'b0, (k == 7) ? 5'b00001 : 5'b0, 5'b0));
    for (int k = 0; k < 10; k++) begin
      @(posedge HCLK); #1;
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL clean_press[%0d]: got sw=%h pb=%b pr=%b rl=%b, required sw=%h pb=%b pr=%b rl=%b",
                 k, obs.sw, obs.pb, obs.pr, obs.rl, e.sw, e.pb, e.pr, e.rl);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    for (int k = 0; k < 14; k++) q.push_back(mk(16'hFFFF, 5'b00001, 5'b0, 5'b0));
    for (int k = 0; k < 14; k++) begin
      PB_raw[2] = (k < 6) && (((k / 2) % 2) == 0);
      @(posedge HCLK); #1;
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL bounce[%0d]: got sw=%h pb=%b pr=%b rl=%b, required sw=%h pb=%b pr=%b rl=%b",
                 k, obs.sw, obs.pb, obs.pr, obs.rl, e.sw, e.pb, e.pr, e.rl);
      end
    end
  endtask

  // Settle switches low, then a 3-cycle glitch, a 4-cycle (longest rejectable)
  // glitch, and finally a held edge on SW_raw[5].
  task automatic test_late_glitch();
    exp_t e;
    int   k;
    for (int j = 0; j < 36; j++) begin
      k = j - 8;
      if (j < 8) q.push_back(mk((j < 6) ? 16'hFFFF : 16'h0, 5'b00001, 5'b0, 5'b0));
      else       q.push_back(mk((k >= 26) ? 16'h0020 : 16'h0, 5'b00001, 5'b0, 5'b0));
    end
    for (int j = 0; j < 36; j++) begin
      k = j - 8;
      if (j < 8) SW_raw = 16'h0;
      else       SW_raw = ((k < 3) || (k >= 10 && k < 14) || (k >= 20)) ? 16'h0020 : 16'h0;
      @(posedge HCLK); #1;
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL late_glitch[%0d]: got sw=%h pb=%b pr=%b rl=%b, required sw=%h pb=%b pr=%b rl=%b",
                 j, obs.sw, obs.pb, obs.pr, obs.rl, e.sw, e.pb, e.pr, e.rl);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    SW_raw = 16'hA5A5;
    PB_raw = 5'b10001;
    for (int k = 0; k < 9; k++) begin
      if (k < 6) q.push_back(mk(16'h0020, 5'b00001, 5'b0, 5'b0));
      else       q.push_back(mk(16'hA5A5, 5'b10001, (k == 7) ? 5'b10000 : 5'b0, 5'b0));
    end
    for (int k = 0; k < 9; k++) begin
      @(posedge HCLK); #1;
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL simultaneous[%0d]: got sw=%h pb=%b pr=%b rl=%b, required sw=%h pb=%b pr=%b rl=%b",
                 k, obs.sw, obs.pb, obs.pr, obs.rl, e.sw, e.pb, e.pr, e.rl);
      end
    end
  endtask

  task automatic test_release();
    exp_t e;
    PB_raw = 5'b00000;
    for (int k = 0; k < 9; k++)
      q.push_back(mk(16'hA5A5, (k >= 6) ? 5'b0 : 5'b10001, 5'b0, (k == 7) ? 5'b10001 : 5'b0));
    for (int k = 0; k < 9; k++) begin
      @(posedge HCLK); #1;
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL release[%0d]: got sw=%h pb=%b pr=%b rl=%b, required sw=%h pb=%b pr=%b rl=%b",
                 k, obs.sw, obs.pb, obs.pr, obs.rl, e.sw, e.pb, e.pr, e.rl);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    PB_raw = 5'b00010;
    for (int k = 0; k < 2; k++) q.push_back(mk(16'hA5A5, 5'b0, 5'b0, 5'b0));
    for (int k = 0; k < 2; k++) begin
      @(posedge HCLK); #1;
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mid_reset_pre[%0d]: got sw=%h pb=%b pr=%b rl=%b, required sw=%h pb=%b pr=%b rl=%b",
                 k, obs.sw, obs.pb, obs.pr, obs.rl, e.sw, e.pb, e.pr, e.rl);
      end
    end
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got sw=%h pb=%b pr=%b rl=%b, required all zero",
               obs.sw, obs.pb, obs.pr, obs.rl);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK); #1;
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL mid_reset_hold[%0d]: got sw=%h pb=%b pr=%b rl=%b, required all zero",
                 k, obs.sw, obs.pb, obs.pr, obs.rl);
      end
    end
    HRESETn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 6) q.push_back(mk(16'h0, 5'b0, 5'b0, 5'b0));
      else       q.push_back(mk(16'hA5A5, 5'b00010, (k == 7) ? 5'b00010 : 5'b0, 5'b0));
    end
    for (int k = 0; k < 9; k++) begin
      @(posedge HCLK); #1;
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mid_reset_post[%0d]: got sw=%h pb=%b pr=%b rl=%b, required sw=%h pb=%b pr=%b rl=%b",
                 k, obs.sw, obs.pb, obs.pr, obs.rl, e.sw, e.pb, e.pr, e.rl);
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    SW_raw  = '0;
    PB_raw  = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_late_glitch();
    test_simultaneous();
    test_release();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
